// File: rtl/bsg_mem_1rw_port_scheduler.sv
// ============================================================================
// Module      : bsg_mem_1rw_port_scheduler
// Description : Serializes independent write and read request streams onto the
//               single ce/we/addr port of a 1rw SRAM macro. Writes are posted
//               into a 2-entry buffer; reads win the port and forward from it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bsg_mem_1rw_port_scheduler #(
    parameter int width_p    = 32,
    parameter int els_p      = 8,
    parameter int wbuf_els_p = 2,
    localparam int lg_els_lp = $clog2(els_p)
) (
    input  logic                 clk_i,
    input  logic                 reset_i,

    input  logic                 w_v_i,
    input  logic [lg_els_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]   w_data_i,
    output logic                 w_ready_o,

    input  logic                 r_v_i,
    input  logic [lg_els_lp-1:0] r_addr_i,
    output logic                 r_ready_o,

    output logic                 r_v_o,
    output logic [width_p-1:0]   r_data_o,
    input  logic                 r_yumi_i,

    output logic                 sram_ce_o,
    output logic                 sram_we_o,
    output logic [lg_els_lp-1:0] sram_addr_o,
    output logic [width_p-1:0]   sram_wd_o,
    output logic [width_p-1:0]   sram_w_mask_o,
    input  logic [width_p-1:0]   sram_rd_i
);

    // Buffer depth is fixed at two entries; entry 0 is always the head.
    localparam logic [1:0] c_wbuf_full = 2'(wbuf_els_p);

    logic [lg_els_lp-1:0] r_wbuf_addr [2];
    logic [width_p-1:0]   r_wbuf_data [2];
    logic [1:0]           r_count;

    logic                 r_v;
    logic                 r_rd_pend;
    logic [width_p-1:0]   r_hold;
    logic [lg_els_lp-1:0] r_last_addr;
    logic [width_p-1:0]   r_last_wd;

    logic                 w_wr_acc;
    logic                 w_rd_acc;
    logic                 w_hit0;
    logic                 w_hit1;
    logic                 w_hit;
    logic [width_p-1:0]   w_fwd_data;
    logic                 w_rd_issue;
    logic                 w_drain;
    logic [1:0]           w_tail;
    logic [lg_els_lp-1:0] w_wbuf_addr_n [2];
    logic [width_p-1:0]   w_wbuf_data_n [2];

    // ------------------------------------------------------------------------
    // Handshakes and arbitration
    // ------------------------------------------------------------------------
    assign w_ready_o = ~reset_i & (r_count < c_wbuf_full);
    // A full buffer blocks reads so the next cycle is guaranteed to drain.
    assign r_ready_o = ~reset_i & (r_count < c_wbuf_full)
                     & (~r_v | r_yumi_i) & ~r_rd_pend;

    assign w_wr_acc = w_v_i & w_ready_o;
    assign w_rd_acc = r_v_i & r_ready_o;

    // Forwarding looks only at entries present before this cycle's enqueue.
    assign w_hit0 = (r_count != 2'd0) & (r_wbuf_addr[0] == r_addr_i);
    assign w_hit1 = (r_count == c_wbuf_full) & (r_wbuf_addr[1] == r_addr_i);
    assign w_hit  = w_hit0 | w_hit1;
    assign w_fwd_data = w_hit1 ? r_wbuf_data[1] : r_wbuf_data[0];

    assign w_rd_issue = w_rd_acc & ~w_hit;
    assign w_drain    = (r_count != 2'd0) & ~w_rd_issue;

    assign sram_ce_o     = w_rd_issue | w_drain;
    assign sram_we_o     = w_drain;
    assign sram_addr_o   = w_rd_issue ? r_addr_i
                         : w_drain    ? r_wbuf_addr[0]
                         :              r_last_addr;
    assign sram_wd_o     = w_drain ? r_wbuf_data[0] : r_last_wd;
    assign sram_w_mask_o = '0;

    assign r_v_o    = r_v;
    assign r_data_o = r_rd_pend ? sram_rd_i : r_hold;

    // ------------------------------------------------------------------------
    // Posted-write buffer next state: shift on drain, then write at the tail
    // ------------------------------------------------------------------------
    assign w_tail = r_count - {1'b0, w_drain};

    always_comb begin
        w_wbuf_addr_n[0] = r_wbuf_addr[0];
        w_wbuf_addr_n[1] = r_wbuf_addr[1];
        w_wbuf_data_n[0] = r_wbuf_data[0];
        w_wbuf_data_n[1] = r_wbuf_data[1];
        if (w_drain) begin
            w_wbuf_addr_n[0] = r_wbuf_addr[1];
            w_wbuf_data_n[0] = r_wbuf_data[1];
        end
        if (w_wr_acc) begin
            if (w_tail == 2'd0) begin
                w_wbuf_addr_n[0] = w_addr_i;
                w_wbuf_data_n[0] = w_data_i;
            end else begin
                w_wbuf_addr_n[1] = w_addr_i;
                w_wbuf_data_n[1] = w_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wbuf_addr[0] <= '0;
            r_wbuf_addr[1] <= '0;
            r_wbuf_data[0] <= '0;
            r_wbuf_data[1] <= '0;
            r_count        <= 2'd0;
        end else begin
            r_wbuf_addr[0] <= w_wbuf_addr_n[0];
            r_wbuf_addr[1] <= w_wbuf_addr_n[1];
            r_wbuf_data[0] <= w_wbuf_data_n[0];
            r_wbuf_data[1] <= w_wbuf_data_n[1];
            r_count        <= r_count - {1'b0, w_drain} + {1'b0, w_wr_acc};
        end
    end

    // ------------------------------------------------------------------------
    // Read return path and idle-port address/data hold
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_v         <= 1'b0;
            r_rd_pend   <= 1'b0;
            r_hold      <= '0;
            r_last_addr <= '0;
            r_last_wd   <= '0;
        end else begin
            r_v       <= w_rd_acc | (r_v & ~r_yumi_i);
            r_rd_pend <= w_rd_issue;
            // Macro data is only valid for one cycle, so it is parked here.
            if (w_rd_acc & w_hit) begin
                r_hold <= w_fwd_data;
            end else if (r_rd_pend) begin
                r_hold <= sram_rd_i;
            end
            if (sram_ce_o) begin
                r_last_addr <= sram_addr_o;
            end
            if (w_drain) begin
                r_last_wd <= r_wbuf_data[0];
            end
        end
    end

`ifndef SYNTHESIS
    a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (reset_i)
        r_yumi_i |-> r_v);
    a_w_addr_known: assert property (@(posedge clk_i) disable iff (reset_i)
        w_v_i |-> !$isunknown(w_addr_i));
    a_r_addr_known: assert property (@(posedge clk_i) disable iff (reset_i)
        r_v_i |-> !$isunknown(r_addr_i));
`endif

endmodule

`default_nettype wire
